// File: rtl/i2c_pkg.sv
// ============================================================================
// Package  : i2c_pkg
// Brief    : Shared state encoding and bit timing for the I2C master.
// Revision : 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

  localparam int BIT_CYCLES = 2;

  // Encodings are fixed so the state can be read directly on a debug probe
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    START      = 4'd1,
    ADDR       = 4'd2,
    RW         = 4'd3,
    ACK_WAIT   = 4'd4,
    WRITE_BYTE = 4'd5,
    MASTER_ACK = 4'd6,
    READ_HI    = 4'd7,
    READ_LO    = 4'd8,
    STOP       = 4'd9
  } state_t;

  // What an acknowledge slot follows, which decides where the FSM goes next
  typedef enum logic [1:0] {
    ACK_ADDR = 2'd0,
    ACK_MORE = 2'd1,
    ACK_LAST = 2'd2
  } ack_kind_t;

endpackage

`default_nettype wire

// File: rtl/i2c_master_if.sv
// ============================================================================
// Interface : i2c_master_if
// Brief     : Host request/response and SCL/SDA pad signals of the I2C master.
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface i2c_master_if;

  logic        start;
  logic        rw;
  logic        two_bytes;
  logic [6:0]  addr;
  logic [15:0] data;
  logic        ready;
  logic [15:0] read_data;
  logic        scl_in;
  logic        sda_in;
  logic        scl_out;
  logic        sda_out;

  modport master (
    input  start, rw, two_bytes, addr, data, scl_in, sda_in,
    output ready, read_data, scl_out, sda_out
  );

  modport slave (
    output start, rw, two_bytes, addr, data, scl_in, sda_in,
    input  ready, read_data, scl_out, sda_out
  );

endinterface

`default_nettype wire

// File: rtl/i2c_bit_timer.sv
// ============================================================================
// Module   : i2c_bit_timer
// Brief    : Phase counter giving the SCL-high phase and the end-of-bit strobe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_bit_timer
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic scl_hi,
  output logic sample
);

  localparam int c_cnt_w = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BIT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(BIT_CYCLES / 2);

  logic [c_cnt_w-1:0] r_cnt;

  // Held at zero while idle so every transaction starts on phase 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!en || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign scl_hi = (r_cnt >= c_half);
  assign sample = en && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/i2c_master.sv
// ============================================================================
// Module   : i2c_master
// Brief    : Single-master I2C controller, one addressed 1/2-byte transfer per start.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_master
  import i2c_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  i2c_master_if.master bus
);

  state_t      r_state, w_next_state;
  ack_kind_t   r_ack_kind, w_next_ack_kind;
  logic [3:0]  r_count, w_next_count;
  logic [6:0]  r_addr;
  logic [15:0] r_data;
  logic        r_rw;
  logic        r_two;
  logic [15:0] r_read_data;
  logic        w_scl_hi;
  logic        w_sample;
  logic        w_bus_free;
  logic        w_accept;
  logic        w_sda;

  i2c_bit_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (r_state != IDLE),
    .scl_hi (w_scl_hi),
    .sample (w_sample)
  );

  assign w_bus_free    = bus.scl_in && bus.sda_in;
  assign bus.ready     = (r_state == IDLE) && w_bus_free;
  assign bus.scl_out   = ((r_state == IDLE) || (r_state == START)) ? 1'b1 : w_scl_hi;
  assign bus.sda_out   = w_sda;
  assign bus.read_data = r_read_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_ack_kind <= ACK_ADDR;
    end else begin
      r_state    <= w_next_state;
      r_count    <= w_next_count;
      r_ack_kind <= w_next_ack_kind;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= 7'd0;
      r_data      <= 16'd0;
      r_rw        <= 1'b0;
      r_two       <= 1'b0;
      r_read_data <= 16'd0;
    end else begin
      if (w_accept) begin
        r_addr <= bus.addr;
        r_data <= bus.data;
        r_rw   <= bus.rw;
        r_two  <= bus.two_bytes;
        if (bus.rw && !bus.two_bytes) begin
          r_read_data[15:8] <= 8'd0;
        end
      end
      if (w_sample && ((r_state == READ_HI) || (r_state == READ_LO))) begin
        r_read_data[r_count] <= bus.sda_in;
      end
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_next_count    = r_count;
    w_next_ack_kind = r_ack_kind;
    w_sda           = 1'b1;
    w_accept        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && w_bus_free) begin
          w_accept     = 1'b1;
          w_next_state = START;
        end
      end
      START: begin
        // SDA falls in the second half while SCL stays high
        w_sda = ~w_scl_hi;
        if (w_sample) begin
          w_next_state = ADDR;
          w_next_count = 4'd6;
        end
      end
      ADDR: begin
        w_sda = r_addr[r_count[2:0]];
        if (w_sample) begin
          if (r_count == 4'd0) begin
            w_next_state = RW;
          end else begin
            w_next_count = r_count - 4'd1;
          end
        end
      end
      RW: begin
        w_sda = r_rw;
        if (w_sample) begin
          w_next_state    = ACK_WAIT;
          w_next_ack_kind = ACK_ADDR;
          w_next_count    = r_two ? 4'd15 : 4'd7;
        end
      end
      ACK_WAIT: begin
        if (w_sample) begin
          if (bus.sda_in) begin
            w_next_state = STOP;
          end else begin
            case (r_ack_kind)
              ACK_ADDR: begin
                if (!r_rw) begin
                  w_next_state = WRITE_BYTE;
                end else begin
                  w_next_state = r_two ? READ_HI : READ_LO;
                end
              end
              ACK_MORE: w_next_state = WRITE_BYTE;
              default:  w_next_state = STOP;
            endcase
          end
        end
      end
      WRITE_BYTE: begin
        w_sda = r_data[r_count];
        if (w_sample) begin
          if (r_count == 4'd8) begin
            w_next_state    = ACK_WAIT;
            w_next_ack_kind = ACK_MORE;
            w_next_count    = 4'd7;
          end else if (r_count == 4'd0) begin
            w_next_state    = ACK_WAIT;
            w_next_ack_kind = ACK_LAST;
          end else begin
            w_next_count = r_count - 4'd1;
          end
        end
      end
      READ_HI: begin
        if (w_sample) begin
          if (r_count == 4'd8) begin
            w_next_state    = MASTER_ACK;
            w_next_ack_kind = ACK_MORE;
            w_next_count    = 4'd7;
          end else begin
            w_next_count = r_count - 4'd1;
          end
        end
      end
      READ_LO: begin
        if (w_sample) begin
          if (r_count == 4'd0) begin
            w_next_state    = MASTER_ACK;
            w_next_ack_kind = ACK_LAST;
          end else begin
            w_next_count = r_count - 4'd1;
          end
        end
      end
      MASTER_ACK: begin
        // ACK keeps the slave sending; NACK on the final byte ends the read
        w_sda = (r_ack_kind == ACK_LAST);
        if (w_sample) begin
          w_next_state = (r_ack_kind == ACK_LAST) ? STOP : READ_LO;
        end
      end
      STOP: begin
        // SDA is held low here and released on the return to IDLE with SCL high
        w_sda = 1'b0;
        if (w_sample) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master.sv
// ============================================================================
// Module   : tb_i2c_master
// Brief    : Bus-level model of each transaction compared cycle by cycle with the DUT.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_master_if bus ();

  logic slave_sda = 1'b1;
  logic force_scl = 1'b1;
  logic force_sda = 1'b1;
  assign bus.scl_in = bus.scl_out & force_scl;
  assign bus.sda_in = bus.sda_out & slave_sda & force_sda;

  i2c_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_vec = 0;
  int n_err = 0;

  // Expected bus picture: per cycle SCL, master SDA and slave SDA drive
  bit   q_scl[$];
  bit   q_sda[$];
  bit   q_drv[$];
  logic cap[$];
  logic [15:0] last_rd = 16'h0;

  logic exp_valid = 1'b0;
  logic exp_scl = 1'b1;
  logic exp_sda = 1'b1;
  logic exp_rdy = 1'b1;

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      check("scl_out", 16'(bus.scl_out), 16'(exp_scl));
      check("sda_out", 16'(bus.sda_out), 16'(exp_sda));
      check("ready",   16'(bus.ready),   16'(exp_rdy));
    end
  end

  task automatic set_exp(bit s, bit d, bit r);
    exp_scl = s;
    exp_sda = d;
    exp_rdy = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      set_exp(1'b1, 1'b1, 1'b1);
      tick();
    end
  endtask

  task automatic put(bit s, bit d, bit v);
    q_scl.push_back(s);
    q_sda.push_back(d);
    q_drv.push_back(v);
  endtask

  task automatic put_bit(bit b, bit v);
    put(1'b0, b, v);
    put(1'b1, b, v);
  endtask

  task automatic build(bit rw, bit two, logic [6:0] a, logic [15:0] d, bit ack, logic [15:0] sdata);
    q_scl.delete();
    q_sda.delete();
    q_drv.delete();
    put(1'b1, 1'b1, 1'b1);
    put(1'b1, 1'b0, 1'b1);
    for (int i = 6; i >= 0; i--) put_bit(a[i], 1'b1);
    put_bit(rw, 1'b1);
    put_bit(1'b1, !ack);
    if (ack) begin
      for (int k = (two ? 1 : 0); k >= 0; k--) begin
        for (int i = 7; i >= 0; i--) begin
          if (!rw) put_bit(d[8*k+i], 1'b1);
          else     put_bit(1'b1, sdata[8*k+i]);
        end
        if (!rw) put_bit(1'b1, 1'b0);
        else     put_bit((k == 0), 1'b1);
      end
    end
    put(1'b0, 1'b0, 1'b1);
    put(1'b1, 1'b0, 1'b1);
  endtask

  function automatic logic [7:0] cap_byte(int k);
    logic [7:0] r = 'x;
    if (cap.size() >= k*9 + 8) begin
      for (int i = 0; i < 8; i++) r[7-i] = cap[k*9+i];
    end
    return r;
  endfunction

  function automatic logic cap_bit(int j);
    return (cap.size() > j) ? cap[j] : 1'bx;
  endfunction

  task automatic run(string name, bit rw, bit two, logic [6:0] a, logic [15:0] d,
                     bit ack, logic [15:0] sdata, int exp_len, int reset_at);
    int busy = 0;
    build(rw, two, a, d, ack, sdata);
    check({name, " model length"}, 16'(q_scl.size()), 16'(exp_len));
    cap.delete();
    bus.start = 1'b1; bus.rw = rw; bus.two_bytes = two; bus.addr = a; bus.data = d;
    set_exp(1'b1, 1'b1, 1'b1);
    tick();
    // Scramble the request so only latched values can reach the bus
    bus.start = 1'b0; bus.rw = ~rw; bus.two_bytes = ~two; bus.addr = ~a; bus.data = ~d;
    for (int i = 0; i < q_scl.size(); i++) begin
      slave_sda = q_drv[i];
      set_exp(q_scl[i], q_sda[i], 1'b0);
      if (!bus.ready) busy++;
      if ((i >= 2) && (i % 2 == 1) && (i < q_scl.size() - 2)) cap.push_back(bus.sda_out);
      if (i == reset_at) begin
        @(negedge clk);
        #1;
        rst = 1'b0;
        set_exp(1'b1, 1'b1, 1'b1);
        slave_sda = 1'b1;
        #1;
        check({name, " reset scl"}, 16'(bus.scl_out), 16'h1);
        check({name, " reset sda"}, 16'(bus.sda_out), 16'h1);
        last_rd = 16'h0;
        tick();
        tick();
        rst = 1'b1;
        check({name, " reset read_data"}, bus.read_data, last_rd);
        idle(2);
        return;
      end
      tick();
    end
    slave_sda = 1'b1;
    set_exp(1'b1, 1'b1, 1'b1);
    check({name, " busy cycles"}, 16'(busy), 16'(exp_len));
    if (rw && !two) last_rd[15:8] = 8'h00;
    if (rw && ack) last_rd = two ? sdata : {8'h00, sdata[7:0]};
    check({name, " read_data"}, bus.read_data, last_rd);
    tick();
    idle(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.rw = 1'b0; bus.two_bytes = 1'b0; bus.addr = 7'h0; bus.data = 16'h0;
    set_exp(1'b1, 1'b1, 1'b1);
    exp_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check("reset read_data", bus.read_data, 16'h0000);
    idle(2);

    // SDA held low by another agent: start must be ignored
    force_sda = 1'b0;
    bus.addr = 7'h50;
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2);
      set_exp(1'b1, 1'b1, 1'b0);
      tick();
    end
    bus.start = 1'b0;
    force_sda = 1'b1;
    idle(3);
    force_scl = 1'b0;
    for (int i = 0; i < 3; i++) begin set_exp(1'b1, 1'b1, 1'b0); tick(); end
    force_sda = 1'b0;
    for (int i = 0; i < 3; i++) begin set_exp(1'b1, 1'b1, 1'b0); tick(); end
    force_scl = 1'b1;
    force_sda = 1'b1;
    idle(2);

    run("nack_wr", 1'b0, 1'b0, 7'h50, 16'hAA55, 1'b0, 16'h0, 22, -1);
    check("nack_wr addr byte", 16'(cap_byte(0)), 16'h00A0);

    run("wr1", 1'b0, 1'b0, 7'h50, 16'hAA55, 1'b1, 16'h0, 40, -1);
    check("wr1 addr byte", 16'(cap_byte(0)), 16'h00A0);
    check("wr1 data byte", 16'(cap_byte(1)), 16'h0055);

    run("wr2", 1'b0, 1'b1, 7'h50, 16'hAA55, 1'b1, 16'h0, 58, -1);
    check("wr2 addr byte", 16'(cap_byte(0)), 16'h00A0);
    check("wr2 hi byte",   16'(cap_byte(1)), 16'h00AA);
    check("wr2 lo byte",   16'(cap_byte(2)), 16'h0055);

    run("rd2", 1'b1, 1'b1, 7'h50, 16'h0000, 1'b1, 16'hA7B8, 58, -1);
    check("rd2 addr byte",  16'(cap_byte(0)), 16'h00A1);
    check("rd2 value",      bus.read_data, 16'hA7B8);
    check("rd2 master ack", 16'(cap_bit(17)), 16'h0000);
    check("rd2 master nack", 16'(cap_bit(26)), 16'h0001);

    run("rd1", 1'b1, 1'b0, 7'h50, 16'h0000, 1'b1, 16'h33B8, 40, -1);
    check("rd1 value",       bus.read_data, 16'h00B8);
    check("rd1 master nack", 16'(cap_bit(17)), 16'h0001);

    run("rst_mid", 1'b0, 1'b0, 7'h50, 16'hAA55, 1'b1, 16'h0, 40, 6);

    run("wr_after_rst", 1'b0, 1'b0, 7'h2C, 16'h00C3, 1'b1, 16'h0, 40, -1);
    check("wr_after_rst addr byte", 16'(cap_byte(0)), 16'h0058);
    check("wr_after_rst data byte", 16'(cap_byte(1)), 16'h00C3);

    exp_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_master.md
# i2c_master

Single-master I2C controller that performs one addressed transaction per `start` pulse: a 1- or 2-byte write, or a 1- or 2-byte read, from a 7-bit slave address. It sits between a register-level host interface and the open-drain SCL/SDA pad cells. It reports bus availability on `ready` and returns read data on a 16-bit port.

## Interface
- No parameters. Bit period is fixed at 2 `clk` cycles.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; accepted only while `ready`=1.
- `rw`  in  1  0 = write, 1 = read.
- `two_bytes`  in  1  0 = one data byte, 1 = two data bytes.
- `addr`  in  7  slave address.
- `data`  in  16  write data.
- `scl_in`  in  1  sensed SCL level; Z or 1 means released.
- `sda_in`  in  1  sensed SDA level.
- `scl_out`  out  1  SCL drive; 0 pulls low, 1 releases.
- `sda_out`  out  1  SDA drive; 0 pulls low, 1 releases.
- `ready`  out  1  idle and bus free.
- `read_data`  out  16  last read result.

## Operation
- State encoding is fixed for debug visibility:
  - 0 IDLE
  - 1 START
  - 2 ADDR
  - 3 RW
  - 4 ACK_WAIT
  - 5 WRITE_BYTE
  - 6 MASTER_ACK
  - 7 READ_HI
  - 8 READ_LO
  - 9 STOP
- `count` is a 4-bit bit index, MSB first.
- IDLE: `ready` = (`scl_in` != 0) && (`sda_in` != 0). An accepted `start` latches `addr`, `data`, `rw` and `two_bytes`, then moves to START. `start` while not ready is ignored; no queuing.
- START: SDA falls while SCL is high. Go to ADDR.
- ADDR: shift `addr[6:0]`.
- RW: send the latched `rw` bit. Go to ACK_WAIT.
- ACK_WAIT: release SDA and sample `sda_in` at the SCL-high phase.
  - 1 (NACK): go to STOP and abort.
  - 0 (ACK) after the address, write: go to WRITE_BYTE.
  - 0 (ACK) after the address, read: go to READ_HI if `two_bytes`, else READ_LO.
  - 0 (ACK) after a written byte: go to the next byte, or to STOP after the last byte.
- WRITE_BYTE:
  - Two bytes: send `data[15:8]` (count 15..8), then `data[7:0]` (count 7..0).
  - One byte: send `data[7:0]` only.
  - Each byte is followed by ACK_WAIT.
- READ_HI: release SDA and sample `sda_in` into `read_data[count]` for count 15..8. Go to MASTER_ACK with SDA low (ACK), then READ_LO.
- READ_LO: sample into `read_data[count]` for count 7..0. Go to MASTER_ACK with SDA released (NACK), then STOP.
- One-byte read: `read_data[15:8]` is cleared to 0 when the transaction starts.
- STOP: SDA rises while SCL is high. Return to IDLE.
- There is no clock stretching and no arbitration. `scl_in` is used only for the `ready` computation.

## Timing
- Each bit takes 2 cycles:
  - phase 0: `scl_out`=0 and SDA updates;
  - phase 1: `scl_out`=1 and SDA is sampled at the end of the phase.
- START and STOP each take 2 cycles.
- The cycle after an accepted `start`, `ready`=0 and the state is START.
- Transaction lengths in cycles:
  - 1-byte write with ACKs: 2+16+2+16+2+2 = 40.
  - 2-byte write: 58.
  - 1-byte read: 40.
  - 2-byte read: 58.
  - Address NACK: 22 cycles, then IDLE.
- `read_data` bits update on the sampling edge and hold until the next read transaction.
- Reset values: state IDLE, `scl_out`=1, `sda_out`=1, `read_data`=0, `count`=0. `ready` follows the bus condition.
- Reset asserted mid-transaction releases both lines immediately and returns to IDLE. No STOP is generated.

## Structure
- Shared package `i2c_pkg`: state enum with the fixed encodings above, and `BIT_CYCLES`=2.
- One natural sub-module, `i2c_bit_timer`: the phase counter that generates `scl_out` and a sample strobe. Everything else is a single FSM.

## Test plan
- Bus busy:
  - `sda_in`=0 for 5 cycles -> `ready`=0 and a `start` in that window is ignored.
  - `scl_in`=0 -> `ready`=0.
  - Both low -> `ready`=0.
  - Released -> `ready`=1.
- 1-byte write, addr 0x50, data 0xAA55, no slave ACK -> SDA shows 0xA0 (address 0x50 then rw=0), NACK detected, STOP, IDLE after 22 cycles, `ready`=1.
- 1-byte write with slave ACKs -> SDA shows 0xA0 then 0x55; 40 cycles total; START and STOP conditions correct.
- 2-byte write of 0xAA55 with ACKs -> bytes 0xA0, 0xAA, 0x55; 58 cycles.
- 1-byte read with slave driving 0xB8 -> `read_data`=0x00B8, master NACK, STOP.
- 2-byte read with slave driving 0xA7B8 -> `read_data`=0xA7B8, master ACK after the high byte, NACK after the low byte.
- Reset asserted mid-write -> `scl_out`=`sda_out`=1 immediately, state IDLE.
